full_adder_gl: RTL and testbench

- 1-bit gate-level full adder: the basic cell of the TinyRV1 datapath adders, chained as a ripple carry in wider adders.
- Primary outputs sum/cout are purely combinational.
- A registered copy of both outputs is provided for pipelined use. It uses the block's single clock and asynchronous active-low reset.

---
 rtl/half_adder_gl.sv | 12 +
 rtl/full_adder_gl.sv | 45 ++++
 tb/tb_full_adder_gl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/half_adder_gl.sv
// rtl/half_adder_gl.sv - gate-level half adder cell
module half_adder_gl (
  input  logic a,
  input  logic b,
  output logic carry,
  output logic sum
);

  assign carry = a & b;
  assign sum   = a ^ b;

endmodule

// File: rtl/full_adder_gl.sv
// rtl/full_adder_gl.sv - gate-level full adder with registered copy of sum/cout
module full_adder_gl (
  input  logic clk,
  input  logic reset,
  input  logic in0,
  input  logic in1,
  input  logic cin,
  output logic cout,
  output logic sum,
  output logic cout_reg,
  output logic sum_reg
);

  logic ha1_carry;
  logic ha1_sum;
  logic ha2_carry;

  half_adder_gl u_ha1 (
    .a     (in0),
    .b     (in1),
    .carry (ha1_carry),
    .sum   (ha1_sum)
  );

  half_adder_gl u_ha2 (
    .a     (ha1_sum),
    .b     (cin),
    .carry (ha2_carry),
    .sum   (sum)
  );

  // At most one half adder can generate a carry, so OR is enough.
  assign cout = ha1_carry | ha2_carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg  <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      sum_reg  <= sum;
      cout_reg <= cout;
    end
  end

endmodule

// File: tb/tb_full_adder_gl.sv
// tb/tb_full_adder_gl.sv - self-checking bench for full_adder_gl
module tb_full_adder_gl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in0 = 1'b0;
  logic in1 = 1'b0;
  logic cin = 1'b0;
  logic cout;
  logic sum;
  logic cout_reg;
  logic sum_reg;

  int tests = 0;
  int fails = 0;
  bit compare_on = 1'b0;

  logic [1:0] exp_reg = 2'b00;
  logic [1:0] truth [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  full_adder_gl dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .cin      (cin),
    .cout     (cout),
    .sum      (sum),
    .cout_reg (cout_reg),
    .sum_reg  (sum_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_sum(input logic a, input logic b, input logic c);
    int total;
    total = int'(a) + int'(b) + int'(c);
    return total[1:0];
  endfunction

  // Reference for the registered pair: last sampled arithmetic sum, zero under reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_reg = 2'b00;
    else        exp_reg = model_sum(in0, in1, cin);
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      chk("comb_model", {cout, sum}, model_sum(in0, in1, cin));
      chk("reg_model", {cout_reg, sum_reg}, exp_reg);
    end
  end

  task automatic set_in(input logic a, input logic b, input logic c);
    in0 = a;
    in1 = b;
    cin = c;
  endtask

  initial begin
    logic [2:0] v;
    #1 reset = 1'b0;
    #1 chk("reset_regs_async", {cout_reg, sum_reg}, 2'b00);
    @(posedge clk); #1;
    chk("reset_regs_held", {cout_reg, sum_reg}, 2'b00);
    reset = 1'b1;
    compare_on = 1'b1;

    // Basic rows
    @(posedge clk); #1; set_in(0, 0, 0); #8 chk("basic_000", {cout, sum}, 2'b00);
    @(posedge clk); #1; set_in(1, 0, 0); #8 chk("basic_100", {cout, sum}, 2'b01);
    @(posedge clk); #1; set_in(0, 1, 0); #8 chk("basic_010", {cout, sum}, 2'b01);
    @(posedge clk); #1; set_in(1, 1, 0); #8 chk("basic_110", {cout, sum}, 2'b10);

    // Exhaustive in binary order, against the literal truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(posedge clk); #1; set_in(v[2], v[1], v[0]);
      #8 chk($sformatf("truth_%b", v), {cout, sum}, truth[i]);
    end

    // Registered latency
    @(posedge clk); #1; set_in(1, 1, 1);
    @(posedge clk); #1; chk("lat_111", {cout_reg, sum_reg}, 2'b11);
    set_in(0, 0, 1);
    @(posedge clk); #1; chk("lat_001", {cout_reg, sum_reg}, 2'b01);

    // Asynchronous reset mid-cycle
    set_in(1, 1, 1);
    @(posedge clk); #1; chk("pre_reset_regs", {cout_reg, sum_reg}, 2'b11);
    #2 reset = 1'b0;
    #1 chk("async_reset_regs", {cout_reg, sum_reg}, 2'b00);
    chk("comb_in_reset", {cout, sum}, 2'b11);
    @(posedge clk); #1; chk("reset_hold_regs", {cout_reg, sum_reg}, 2'b00);

    // Reset release
    set_in(0, 1, 1);
    #2 reset = 1'b1;
    #5 chk("release_before_edge", {cout_reg, sum_reg}, 2'b00);
    chk("release_comb", {cout, sum}, 2'b10);
    @(posedge clk); #1; chk("release_first_capture", {cout_reg, sum_reg}, 2'b10);

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      set_in(1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        #1 reset = 1'b0;
        #5 reset = 1'b1;
      end
    end

    @(posedge clk); #1;
    compare_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
